// File: rtl/common_pkg.sv
// common_pkg: shared NoC widths, defaults and packet type.
package common_pkg;
  localparam int DEFAULT_VC_W = 2;
  localparam int DEFAULT_A_W = 16;
  localparam int DEFAULT_D_W = 32;
  localparam int DEFAULT_RX_DEPTH = 4;
  typedef struct packed {
    logic                   last;
    logic [DEFAULT_A_W-1:0] addr;
    logic [DEFAULT_D_W-1:0] data;
  } packet_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_if.sv
// noc_if: credit-based NoC link, flit forward and per-VC credit return.
interface noc_if #(
  parameter int VC_W = common_pkg::DEFAULT_VC_W,
  parameter int A_W  = common_pkg::DEFAULT_A_W,
  parameter int D_W  = common_pkg::DEFAULT_D_W
);
  typedef struct packed {
    logic           last;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } pkt_t;
  logic [VC_W-1:0] vc_target;
  pkt_t            packet;
  logic [VC_W-1:0] vc_credit_gnt;
  modport transmitter (output vc_target, output packet, input vc_credit_gnt);
  modport receiver (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: single-VC synchronous FIFO; caller never pushes when full without a pop.
module noc_vc_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RX_DEPTH,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/noc_vc_rx_buffer.sv
// noc_vc_rx_buffer: per-VC receive FIFOs with wormhole round-robin drain and credit return.
module noc_vc_rx_buffer
  import common_pkg::*;
#(
  parameter int VC_W  = DEFAULT_VC_W,
  parameter int A_W   = DEFAULT_A_W,
  parameter int D_W   = DEFAULT_D_W,
  parameter int DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  noc_if.receiver         from_tx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VC_W-1:0] out_vc,
  output logic            out_last,
  output logic [A_W-1:0]  out_addr,
  output logic [D_W-1:0]  out_data,
  output logic            err_overflow,
  output logic            err_multi_vc
);
  localparam int IW = idx_w(VC_W);
  localparam int FW = 1 + A_W + D_W;
  logic [VC_W-1:0] tgt, full, empty, push, pop_vc, sel, scan;
  logic [VC_W-1:0] lock_vc_q, lock_vc_d, hold_vc_q, gnt_q;
  logic [FW-1:0]   head [VC_W];
  logic [FW-1:0]   flit;
  logic [IW-1:0]   rr_q, rr_d, sel_idx, k;
  logic            multi, ovf, pop, locked_q, locked_d, hold_q, ovf_q, multi_q;
  assign tgt    = from_tx.vc_target;
  assign multi  = (tgt & (tgt - VC_W'(1))) != '0;
  // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
  assign push   = multi ? '0 : tgt & (~full | pop_vc);
  assign ovf    = !multi && |(tgt & full & ~pop_vc);
  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    noc_vc_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[v]),
      .pop_i   (pop_vc[v]),
      .din_i   (from_tx.packet),
      .full_o  (full[v]),
      .empty_o (empty[v]),
      .head_o  (head[v])
    );
  end
  // descending scan so the nearest non-empty VC after rr_q is written last
  always_comb begin
    scan = '0;
    k    = '0;
    for (int i = VC_W; i >= 1; i--) begin
      k = IW'((int'(rr_q) + i) % VC_W);
      if (!empty[k]) scan = VC_W'(1) << k;
    end
  end
  assign sel       = locked_q ? lock_vc_q : hold_q ? hold_vc_q : scan;
  assign out_valid = |(sel & ~empty);
  assign out_vc    = out_valid ? sel : '0;
  always_comb begin
    flit    = '0;
    sel_idx = '0;
    for (int v = 0; v < VC_W; v++) begin
      if (sel[v]) begin
        flit    = head[v];
        sel_idx = IW'(v);
      end
    end
  end
  assign {out_last, out_addr, out_data} = flit;
  assign pop    = out_valid && out_ready;
  assign pop_vc = pop ? sel : '0;
  always_comb begin
    locked_d  = pop ? !out_last : locked_q;
    lock_vc_d = pop && !out_last ? sel : lock_vc_q;
    rr_d      = pop && out_last ? sel_idx : rr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      lock_vc_q <= '0;
      rr_q      <= IW'(VC_W - 1);
      hold_q    <= 1'b0;
      hold_vc_q <= '0;
      gnt_q     <= '0;
      ovf_q     <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      lock_vc_q <= lock_vc_d;
      rr_q      <= rr_d;
      hold_q    <= out_valid && !out_ready;
      hold_vc_q <= sel;
      gnt_q     <= pop_vc;
      ovf_q     <= ovf_q | ovf;
      multi_q   <= multi_q | multi;
    end
  end
  assign from_tx.vc_credit_gnt = gnt_q;
  assign err_overflow          = ovf_q;
  assign err_multi_vc          = multi_q;
endmodule

// File: tb/tb_noc_vc_rx_buffer.sv
// tb_noc_vc_rx_buffer: directed scenario checks for the NoC VC receive buffer.
module tb_noc_vc_rx_buffer;
  logic        clk, rst_n, out_ready, out_valid, out_last, err_overflow, err_multi_vc;
  logic [1:0]  out_vc;
  logic [15:0] out_addr;
  logic [31:0] out_data;
  int          checks, failures;
  noc_if #(.VC_W(2), .A_W(16), .D_W(32)) link ();
  noc_vc_rx_buffer #(.VC_W(2), .A_W(16), .D_W(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .from_tx      (link.receiver),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_vc       (out_vc),
    .out_last     (out_last),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .err_overflow (err_overflow),
    .err_multi_vc (err_multi_vc)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic drive(input logic [1:0] t, input logic l, input logic [15:0] a, input logic [31:0] d);
    link.vc_target    = t;
    link.packet.last  = l;
    link.packet.addr  = a;
    link.packet.data  = d;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_vc !== 2'b00) begin failures++; $display("FAIL reset_vc got=%b exp=00", out_vc); end
    checks++; if (link.vc_credit_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", link.vc_credit_gnt); end
    checks++; if ({err_overflow, err_multi_vc} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_overflow, err_multi_vc}); end
    rst_n = 1;
  endtask
  task automatic test_single;
    @(negedge clk); drive(2'b01, 1, 16'd3, 32'hAA); out_ready = 1;
    @(negedge clk); drive(0, 0, 0, 0);
    checks++; if ({out_valid, out_vc, out_last} !== 4'b1011) begin failures++; $display("FAIL single_ctl got=%b exp=1011", {out_valid, out_vc, out_last}); end
    checks++; if (out_addr !== 16'd3 || out_data !== 32'hAA) begin failures++; $display("FAIL single_fields got=%h/%h exp=0003/000000aa", out_addr, out_data); end
    checks++; if (link.vc_credit_gnt !== 2'b00) begin failures++; $display("FAIL single_early_gnt got=%b exp=00", link.vc_credit_gnt); end
    @(negedge clk);
    checks++; if (link.vc_credit_gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", link.vc_credit_gnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (link.vc_credit_gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=00", link.vc_credit_gnt); end
  endtask
  task automatic test_overflow;
    int exp_d, cred1, cred0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(2'b10, 1, 16'h10, (i == 4) ? 32'd9 : 32'(i));
    end
    @(negedge clk); drive(0, 0, 0, 0);
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
    checks++; if (out_vc !== 2'b10 || out_data !== 32'd0) begin failures++; $display("FAIL ovf_head got=%b/%h exp=10/00000000", out_vc, out_data); end
    out_ready = 1; exp_d = 0; cred1 = 0; cred0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        checks++; if (out_data !== 32'(exp_d)) begin failures++; $display("FAIL ovf_order got=%0d exp=%0d", out_data, exp_d); end
        exp_d++;
      end
      cred1 += int'(link.vc_credit_gnt[1]);
      cred0 += int'(link.vc_credit_gnt[0]);
      @(negedge clk);
    end
    checks++; if (exp_d != 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", exp_d); end
    checks++; if (cred1 != 4 || cred0 != 0) begin failures++; $display("FAIL ovf_credits got=%0d/%0d exp=4/0", cred1, cred0); end
  endtask
  task automatic test_interleave;
    logic [1:0]  tg [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic        ls [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] dt [5] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2};
    logic [31:0] ex [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1};
    logic [31:0] got [5];
    int n = 0;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        if (n < 5) got[n] = out_data;
        n++;
      end
      if (i < 5) drive(tg[i], ls[i], 0, dt[i]);
      else drive(0, 0, 0, 0);
      @(negedge clk);
    end
    checks++; if (n != 5) begin failures++; $display("FAIL ilv_count got=%0d exp=5", n); end
    for (int j = 0; j < 5 && j < n; j++) begin
      checks++; if (got[j] !== ex[j]) begin failures++; $display("FAIL ilv_order[%0d] got=%h exp=%h", j, got[j], ex[j]); end
    end
  endtask
  task automatic test_alternate;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive((i % 2) ? 2'b10 : 2'b01, 1, 0, 32'hC0 + 32'(i));
      @(negedge clk);
    end
    drive(0, 0, 0, 0); out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_vc !== ((i % 2) ? 2'b10 : 2'b01) || out_data !== 32'hC0 + 32'(i)) begin failures++; $display("FAIL alt[%0d] got=%b/%h exp=%b/%h", i, out_vc, out_data, (i % 2) ? 2'b10 : 2'b01, 32'hC0 + 32'(i)); end
      @(negedge clk);
    end
  endtask
  task automatic test_stall;
    out_ready = 1; drive(2'b01, 1, 0, 32'h5A);
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk); out_ready = 0; drive(2'b01, 1, 0, 32'h55);
    @(negedge clk); drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid, out_vc} !== 3'b101 || out_data !== 32'h55) begin failures++; $display("FAIL stall[%0d] got=%b/%b/%h exp=1/01/00000055", i, out_valid, out_vc, out_data); end
      if (i == 1) drive(2'b10, 1, 0, 32'h66);
      else drive(0, 0, 0, 0);
      @(negedge clk);
    end
    checks++; if (out_vc !== 2'b01 || out_data !== 32'h55) begin failures++; $display("FAIL stall_held got=%b/%h exp=01/00000055", out_vc, out_data); end
    out_ready = 1;
    @(negedge clk);
    checks++; if (out_vc !== 2'b10 || out_data !== 32'h66) begin failures++; $display("FAIL stall_next got=%b/%h exp=10/00000066", out_vc, out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
  endtask
  task automatic test_multi;
    out_ready = 1;
    checks++; if (err_multi_vc !== 1'b0) begin failures++; $display("FAIL multi_pre got=%b exp=0", err_multi_vc); end
    drive(2'b11, 1, 0, 32'h77);
    @(negedge clk); drive(0, 0, 0, 0);
    checks++; if (err_multi_vc !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL multi_flag got=%b/%b exp=1/0", err_multi_vc, out_valid); end
    @(negedge clk);
    checks++; if (link.vc_credit_gnt !== 2'b00 || out_valid !== 1'b0) begin failures++; $display("FAIL multi_nocredit got=%b/%b exp=00/0", link.vc_credit_gnt, out_valid); end
  endtask
  task automatic test_reset_mid;
    out_ready = 1; drive(2'b01, 0, 0, 32'd1);
    @(negedge clk); drive(2'b01, 0, 0, 32'd2);
    @(negedge clk); drive(0, 0, 0, 0); out_ready = 0;
    checks++; if (link.vc_credit_gnt !== 2'b01 || out_valid !== 1'b1 || out_data !== 32'd2) begin failures++; $display("FAIL mid_pre got=%b/%b/%h exp=01/1/00000002", link.vc_credit_gnt, out_valid, out_data); end
    #2 rst_n = 0;
    #1;
    checks++; if ({out_valid, out_vc, link.vc_credit_gnt} !== 5'b0) begin failures++; $display("FAIL mid_async_out got=%b exp=00000", {out_valid, out_vc, link.vc_credit_gnt}); end
    checks++; if ({err_overflow, err_multi_vc} !== 2'b00) begin failures++; $display("FAIL mid_async_err got=%b exp=00", {err_overflow, err_multi_vc}); end
    @(negedge clk); rst_n = 1; out_ready = 1; drive(2'b10, 1, 0, 32'h88);
    @(negedge clk); drive(0, 0, 0, 0);
    checks++; if (out_vc !== 2'b10 || out_data !== 32'h88) begin failures++; $display("FAIL mid_flushed got=%b/%h exp=10/00000088", out_vc, out_data); end
    @(negedge clk);
  endtask
  initial begin
    checks = 0; failures = 0;
    rst_n = 0; out_ready = 0; drive(0, 0, 0, 0);
    test_reset;
    test_single;
    test_overflow;
    test_interleave;
    test_alternate;
    test_stall;
    test_multi;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
